// File: rtl/apb_req_master_bridge.sv
// Bridges a req/gnt/rvalid data port onto a single-master APB bus, one transfer in flight.
// Zero-wait transfer takes 3 cycles; partial-word writes are rejected and hung slaves time out.
module apb_req_master_bridge #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_i,
  output logic                        gnt_o,
  input  logic [APB_ADDR_WIDTH-1:0]   addr_i,
  input  logic                        we_i,
  input  logic [APB_DATA_WIDTH/8-1:0] be_i,
  input  logic [APB_DATA_WIDTH-1:0]   wdata_i,
  output logic                        rvalid_o,
  output logic [APB_DATA_WIDTH-1:0]   rdata_o,
  output logic                        err_o,
  output logic [APB_ADDR_WIDTH-1:0]   paddr,
  output logic [APB_DATA_WIDTH-1:0]   pwdata,
  output logic                        pwrite,
  output logic                        psel,
  output logic                        penable,
  input  logic [APB_DATA_WIDTH-1:0]   prdata,
  input  logic                        pready,
  input  logic                        pslverr
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, REJECT} state_e;

  state_e                    state_q;
  logic [CW-1:0]             cnt_q;
  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic [APB_DATA_WIDTH-1:0] pwdata_q;
  logic                      pwrite_q;
  logic                      psel_q;
  logic                      penable_q;
  logic                      rvalid_q;
  logic                      err_q;
  logic [APB_DATA_WIDTH-1:0] rdata_q;

  assign gnt_o    = (state_q == IDLE) && req_i;
  assign paddr    = paddr_q;
  assign pwdata   = pwdata_q;
  assign pwrite   = pwrite_q;
  assign psel     = psel_q;
  assign penable  = penable_q;
  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      // Response signals are single-cycle pulses unless re-armed below.
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            if (we_i && (be_i != '1)) begin
              state_q <= REJECT;
            end else begin
              paddr_q  <= {addr_i[APB_ADDR_WIDTH-1:2], 2'b00};
              pwrite_q <= we_i;
              pwdata_q <= wdata_i;
              psel_q   <= 1'b1;
              state_q  <= SETUP;
            end
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rvalid_q  <= 1'b1;
            err_q     <= pslverr;
            rdata_q   <= pwrite_q ? '0 : prdata;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
            // Slave never answered: abort the transfer and report an error.
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rvalid_q  <= 1'b1;
            err_q     <= 1'b1;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        REJECT: begin
          rvalid_q <= 1'b1;
          err_q    <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
